// File: rtl/uart_avm_pkg.sv
// Shared types and constants for the UART Avalon-MM two-port arbiter.
// Holds the arbiter FSM state type, port indices and default bus widths.
package uart_avm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RD_WAIT
    } arb_state_t;

    localparam int unsigned PORT_RX    = 0;
    localparam int unsigned PORT_TX    = 1;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/uart_avm_cmd_latch.sv
// One-entry command latch for a single arbiter port.
// Captures a read or write request while empty and holds it until the arbiter clears it.
module uart_avm_cmd_latch
    import uart_avm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic              clear,
    output logic              valid,
    output logic              is_read,
    output logic [ADDR_W-1:0] cmd_address,
    output logic [DATA_W-1:0] cmd_writedata
);

    // clear only ever targets a full latch and capture only an empty one, so they never collide
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid         <= 1'b0;
            is_read       <= 1'b0;
            cmd_address   <= '0;
            cmd_writedata <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!valid && (read || write)) begin
            valid         <= 1'b1;
            is_read       <= read;
            cmd_address   <= address;
            cmd_writedata <= writedata;
        end
    end

endmodule

// File: rtl/uart_avm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the UART receive and transmit paths.
// One transaction is outstanding downstream at a time; read data is routed back to the owner.
module uart_avm_arbiter
    import uart_avm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic              s0_readdatavalid,
    output logic [DATA_W-1:0] s0_readdata,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic              s1_readdatavalid,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              avm_m1_read,
    output logic              avm_m1_write,
    output logic [ADDR_W-1:0] avm_m1_address,
    output logic [DATA_W-1:0] avm_m1_writedata,
    input  logic              avm_m1_waitrequest,
    input  logic              avm_m1_readdatavalid,
    input  logic [DATA_W-1:0] avm_m1_readdata
);

    logic [1:0]        lat_valid;
    logic [1:0]        lat_read;
    logic [1:0]        lat_clear;
    logic [ADDR_W-1:0] lat_addr [2];
    logic [DATA_W-1:0] lat_data [2];

    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       last, last_nxt;
    logic       grant;

    uart_avm_cmd_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_latch_rx (
        .clk           (clk),
        .rst           (rst),
        .read          (s0_read),
        .write         (s0_write),
        .address       (s0_address),
        .writedata     (s0_writedata),
        .clear         (lat_clear[PORT_RX]),
        .valid         (lat_valid[PORT_RX]),
        .is_read       (lat_read[PORT_RX]),
        .cmd_address   (lat_addr[PORT_RX]),
        .cmd_writedata (lat_data[PORT_RX])
    );

    uart_avm_cmd_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_latch_tx (
        .clk           (clk),
        .rst           (rst),
        .read          (s1_read),
        .write         (s1_write),
        .address       (s1_address),
        .writedata     (s1_writedata),
        .clear         (lat_clear[PORT_TX]),
        .valid         (lat_valid[PORT_TX]),
        .is_read       (lat_read[PORT_TX]),
        .cmd_address   (lat_addr[PORT_TX]),
        .cmd_writedata (lat_data[PORT_TX])
    );

    assign s0_waitrequest = lat_valid[PORT_RX];
    assign s1_waitrequest = lat_valid[PORT_TX];

    // last resets to the TX port so the RX port wins the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'(PORT_RX);
            last  <= 1'(PORT_TX);
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        last_nxt         = last;
        grant            = 1'b0;
        lat_clear        = '0;
        avm_m1_read      = 1'b0;
        avm_m1_write     = 1'b0;
        avm_m1_address   = '0;
        avm_m1_writedata = '0;
        s0_readdatavalid = 1'b0;
        s0_readdata      = '0;
        s1_readdatavalid = 1'b0;
        s1_readdata      = '0;

        case (state)
            IDLE: begin
                if (|lat_valid) begin
                    grant     = (&lat_valid) ? ~last : lat_valid[PORT_TX];
                    owner_nxt = grant;
                    last_nxt  = grant;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                avm_m1_read      = lat_read[owner];
                avm_m1_write     = ~lat_read[owner];
                avm_m1_address   = lat_addr[owner];
                avm_m1_writedata = lat_data[owner];
                if (!avm_m1_waitrequest) begin
                    if (lat_read[owner]) begin
                        state_nxt = RD_WAIT;
                    end else begin
                        lat_clear[owner] = 1'b1;
                        state_nxt        = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_m1_readdatavalid) begin
                    lat_clear[owner] = 1'b1;
                    state_nxt        = IDLE;
                    if (owner == 1'(PORT_TX)) begin
                        s1_readdatavalid = 1'b1;
                        s1_readdata      = avm_m1_readdata;
                    end else begin
                        s0_readdatavalid = 1'b1;
                        s0_readdata      = avm_m1_readdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Self-checking bench for uart_avm_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-slot reference model of the two-port arbiter.
module tb_uart_avm_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    localparam int FREE  = 0;
    localparam int ISSUE = 1;
    localparam int AWAIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_read, s0_write, s1_read, s1_write;
    logic [AW-1:0] s0_address, s1_address;
    logic [DW-1:0] s0_writedata, s1_writedata;
    logic          s0_waitrequest, s0_readdatavalid, s1_waitrequest, s1_readdatavalid;
    logic [DW-1:0] s0_readdata, s1_readdata;
    logic          avm_m1_read, avm_m1_write, avm_m1_waitrequest, avm_m1_readdatavalid;
    logic [AW-1:0] avm_m1_address;
    logic [DW-1:0] avm_m1_writedata, avm_m1_readdata;

    always #5 clk = ~clk;

    uart_avm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s0_read              (s0_read),
        .s0_write             (s0_write),
        .s0_address           (s0_address),
        .s0_writedata         (s0_writedata),
        .s0_waitrequest       (s0_waitrequest),
        .s0_readdatavalid     (s0_readdatavalid),
        .s0_readdata          (s0_readdata),
        .s1_read              (s1_read),
        .s1_write             (s1_write),
        .s1_address           (s1_address),
        .s1_writedata         (s1_writedata),
        .s1_waitrequest       (s1_waitrequest),
        .s1_readdatavalid     (s1_readdatavalid),
        .s1_readdata          (s1_readdata),
        .avm_m1_read          (avm_m1_read),
        .avm_m1_write         (avm_m1_write),
        .avm_m1_address       (avm_m1_address),
        .avm_m1_writedata     (avm_m1_writedata),
        .avm_m1_waitrequest   (avm_m1_waitrequest),
        .avm_m1_readdatavalid (avm_m1_readdatavalid),
        .avm_m1_readdata      (avm_m1_readdata)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: which commands are held per port, and what the single shared slot is doing.
    bit            m_pend [2];
    bit            m_rd   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    int            m_slot;
    int            m_owner;
    int            m_last;

    logic [AW-1:0] wlog [$];

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) m_pend[p] = 0;
        m_slot  = FREE;
        m_owner = 0;
        m_last  = 1;
    endfunction

    task automatic idle_inputs();
        s0_read = 0; s0_write = 0; s0_address = '0; s0_writedata = '0;
        s1_read = 0; s1_write = 0; s1_address = '0; s1_writedata = '0;
        avm_m1_waitrequest = 0; avm_m1_readdatavalid = 0; avm_m1_readdata = '0;
    endtask

    // Called at a negedge with inputs already applied; checks outputs, advances one clock.
    task automatic tick();
        logic [63:0] exp_cmd;
        logic [1:0]  exp_rdv;
        logic [DW-1:0] exp_rd0, exp_rd1;
        bit pb0, pb1, req0, req1;
        #1;
        exp_cmd = '0;
        if (m_slot == ISSUE)
            exp_cmd = 64'({m_rd[m_owner], !m_rd[m_owner], m_addr[m_owner], m_data[m_owner]});
        exp_rdv = 2'b00; exp_rd0 = '0; exp_rd1 = '0;
        if (m_slot == AWAIT && avm_m1_readdatavalid) begin
            if (m_owner == 1) begin exp_rdv = 2'b10; exp_rd1 = avm_m1_readdata; end
            else              begin exp_rdv = 2'b01; exp_rd0 = avm_m1_readdata; end
        end
        check_eq("waitrequest", 64'({s1_waitrequest, s0_waitrequest}), 64'({m_pend[1], m_pend[0]}));
        check_eq("downstream_cmd",
                 64'({avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata}), exp_cmd);
        check_eq("readdatavalid", 64'({s1_readdatavalid, s0_readdatavalid}), 64'(exp_rdv));
        check_eq("s0_readdata", 64'(s0_readdata), 64'(exp_rd0));
        check_eq("s1_readdata", 64'(s1_readdata), 64'(exp_rd1));
        if (avm_m1_write && !avm_m1_waitrequest) wlog.push_back(avm_m1_address);

        pb0  = m_pend[0];
        pb1  = m_pend[1];
        req0 = s0_read || s0_write;
        req1 = s1_read || s1_write;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_slot == FREE) begin
                if (pb0 || pb1) begin
                    m_owner = (pb0 && pb1) ? 1 - m_last : (pb0 ? 0 : 1);
                    m_last  = m_owner;
                    m_slot  = ISSUE;
                end
            end else if (m_slot == ISSUE) begin
                if (!avm_m1_waitrequest) begin
                    if (m_rd[m_owner]) m_slot = AWAIT;
                    else begin m_pend[m_owner] = 0; m_slot = FREE; end
                end
            end else if (avm_m1_readdatavalid) begin
                m_pend[m_owner] = 0;
                m_slot = FREE;
            end
            if (!pb0 && req0) begin
                m_pend[0] = 1; m_rd[0] = s0_read; m_addr[0] = s0_address; m_data[0] = s0_writedata;
            end
            if (!pb1 && req1) begin
                m_pend[1] = 1; m_rd[1] = s1_read; m_addr[1] = s1_address; m_data[1] = s1_writedata;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_random();
        bit r, w;
        for (int p = 0; p < 2; p++) begin
            r = 0; w = 0;
            if ($urandom_range(0, 3) == 0) begin
                r = 1'($urandom_range(0, 1));
                w = !r || ($urandom_range(0, 7) == 0);
            end
            if (p == 0) begin
                s0_read = r; s0_write = w;
                s0_address = AW'($urandom); s0_writedata = $urandom;
            end else begin
                s1_read = r; s1_write = w;
                s1_address = AW'($urandom); s1_writedata = $urandom;
            end
        end
        avm_m1_waitrequest   = ($urandom_range(0, 2) == 0);
        avm_m1_readdatavalid = (m_slot == AWAIT) ? ($urandom_range(0, 2) == 0)
                                                 : ($urandom_range(0, 9) == 0);
        avm_m1_readdata      = $urandom;
        rst = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 1;
        tick();

        // single write from port 0, zero-wait downstream
        s0_write = 1; s0_address = 16'h0010; s0_writedata = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        check_eq("wr_n1_wait", 64'(s0_waitrequest), 64'd1);
        tick();
        check_eq("wr_n2_cmd", 64'({avm_m1_write, avm_m1_address, avm_m1_writedata}),
                 64'({1'b1, 16'h0010, 32'hA5A5A5A5}));
        check_eq("wr_n2_wait", 64'(s0_waitrequest), 64'd1);
        tick();
        check_eq("wr_n3_wait", 64'(s0_waitrequest), 64'd0);
        tick();

        // port 1 read, data returned three cycles after the command is accepted
        s1_read = 1; s1_address = 16'h0020;
        tick();
        idle_inputs();
        tick();
        check_eq("rd_cmd", 64'({avm_m1_read, avm_m1_address}), 64'({1'b1, 16'h0020}));
        tick();
        tick();
        tick();
        avm_m1_readdatavalid = 1; avm_m1_readdata = 32'h12345678;
        #1;
        check_eq("rd_route", 64'({s1_readdatavalid, s1_readdata, s0_readdatavalid}),
                 64'({1'b1, 32'h12345678, 1'b0}));
        tick();
        idle_inputs();
        tick();

        // simultaneous writes from both ports, twice: order must alternate 0,1,0,1
        wlog.delete();
        for (int rep = 0; rep < 2; rep++) begin
            s0_write = 1; s0_address = 16'h0004; s0_writedata = 32'h0000_0004;
            s1_write = 1; s1_address = 16'h0008; s1_writedata = 32'h0000_0008;
            tick();
            idle_inputs();
            for (int c = 0; c < 20 && wlog.size() < 2 * (rep + 1); c++) tick();
        end
        check_eq("order_count", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check_eq("order_addr", 64'((i < wlog.size()) ? wlog[i] : 16'hFFFF),
                     64'((i % 2 == 0) ? 16'h0004 : 16'h0008));

        // downstream stall for five cycles during a write
        wlog.delete();
        s0_write = 1; s0_address = 16'h0030; s0_writedata = 32'hDEADBEEF;
        tick();
        idle_inputs();
        avm_m1_waitrequest = 1;
        tick();
        for (int c = 0; c < 5; c++) begin
            check_eq("stall_cmd", 64'({avm_m1_write, avm_m1_address, avm_m1_writedata}),
                     64'({1'b1, 16'h0030, 32'hDEADBEEF}));
            tick();
        end
        avm_m1_waitrequest = 0;
        tick();
        tick();
        check_eq("stall_single", 64'(wlog.size()), 64'd1);

        // reset while waiting for read data, then late read data
        s1_read = 1; s1_address = 16'h0040;
        tick();
        idle_inputs();
        tick();
        tick();
        rst = 0;
        tick();
        rst = 1;
        avm_m1_readdatavalid = 1; avm_m1_readdata = 32'hCAFEF00D;
        #1;
        check_eq("rst_abandon_rdv", 64'({s1_readdatavalid, s0_readdatavalid}), 64'd0);
        tick();
        idle_inputs();
        check_eq("rst_latches", 64'({s1_waitrequest, s0_waitrequest}), 64'd0);
        check_eq("rst_idle_cmd", 64'({avm_m1_read, avm_m1_write}), 64'd0);

        // spurious read data while idle
        avm_m1_readdatavalid = 1; avm_m1_readdata = 32'h5555AAAA;
        #1;
        check_eq("spurious_rdv", 64'({s1_readdatavalid, s0_readdatavalid, s0_readdata, s1_readdata}),
                 64'd0);
        tick();
        idle_inputs();
        tick();

        for (int c = 0; c < 4000; c++) begin
            drive_random();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
